// File: rtl/seg7_pkg.sv
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared seven-segment codes, checker state encoding and helpers
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

    // Active-low {a,b,c,d,e,f,g}; shared with the counter's encoder
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    localparam logic [3:0] DIG_BAD   = 4'hF;
    localparam logic [6:0] MAX_COUNT = 7'd99;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_SYNC  = 2'd1,
        ST_TRACK = 2'd2
    } state_e;

    function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] sum;
        sum = ({4'b0000, tens} * 8'd10) + {4'b0000, ones};
        return sum[6:0];
    endfunction

    // Value the counter should show one cycle after showing prev
    function automatic logic [6:0] next_expected(input logic [6:0] prev,
                                                 input logic       up,
                                                 input logic       hold);
        logic [6:0] nxt;
        if (hold)
            nxt = prev;
        else if (up)
            nxt = (prev == MAX_COUNT) ? 7'd0 : prev + 7'd1;
        else
            nxt = (prev == 7'd0) ? MAX_COUNT : prev - 7'd1;
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
//  Module      : seg7_decode
//  Description : Active-low seven-segment pattern to BCD digit with legal flag
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] digit_o,
    output logic       legal_o
);

    always_comb begin
        digit_o = DIG_BAD;
        legal_o = 1'b1;
        case (seg_i)
            SEG_0:   digit_o = 4'd0;
            SEG_1:   digit_o = 4'd1;
            SEG_2:   digit_o = 4'd2;
            SEG_3:   digit_o = 4'd3;
            SEG_4:   digit_o = 4'd4;
            SEG_5:   digit_o = 4'd5;
            SEG_6:   digit_o = 4'd6;
            SEG_7:   digit_o = 4'd7;
            SEG_8:   digit_o = 4'd8;
            SEG_9:   digit_o = 4'd9;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg_count_checker.sv
// ============================================================================
//  Module      : seg_count_checker
//  Description : Decodes the 00-99 counter display and flags illegal or
//                out-of-sequence values against the expected count
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module seg_count_checker
    import seg7_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ud,
    input  logic             pause,
    input  logic [6:0]       onesseg,
    input  logic [6:0]       tensseg,
    output logic [3:0]       ONE,
    output logic [3:0]       TEN,
    output logic [6:0]       value,
    output logic             locked,
    output logic             err,
    output logic             bad_seg,
    output logic [ERR_W-1:0] err_cnt,
    output logic [6:0]       first_err_val
);

    logic [3:0] w_one;
    logic [3:0] w_ten;
    logic       w_one_ok;
    logic       w_ten_ok;
    logic       w_legal;
    logic [6:0] w_val;
    logic [6:0] w_exp;

    state_e     state_q, state_d;
    logic [3:0] one_q, ten_q;
    logic [6:0] value_q, prev_q;
    logic       prev_ud_q, prev_pause_q;
    logic       err_q, err_d;
    logic       bad_q, bad_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic [6:0] first_q, first_d;
    logic       seen_q, seen_d;
    logic       count_err;

    seg7_decode u_dec_ones (
        .seg_i   (onesseg),
        .digit_o (w_one),
        .legal_o (w_one_ok)
    );

    seg7_decode u_dec_tens (
        .seg_i   (tensseg),
        .digit_o (w_ten),
        .legal_o (w_ten_ok)
    );

    assign w_legal = w_one_ok & w_ten_ok;
    assign w_val   = bcd_to_bin(w_ten, w_one);
    assign w_exp   = next_expected(prev_q, prev_ud_q, prev_pause_q);

    always_comb begin
        state_d   = state_q;
        err_d     = 1'b0;
        bad_d     = 1'b0;
        first_d   = first_q;
        seen_d    = seen_q;
        count_err = 1'b0;
        cnt_d     = cnt_q;

        case (state_q)
            ST_RESET: state_d = ST_SYNC;
            ST_SYNC: begin
                if (w_legal)
                    state_d = ST_TRACK;
            end
            ST_TRACK: begin
                // An illegal digit hides any simultaneous mismatch
                if (!w_legal) begin
                    bad_d     = 1'b1;
                    count_err = 1'b1;
                    state_d   = ST_SYNC;
                end else if (w_val != w_exp) begin
                    err_d     = 1'b1;
                    count_err = 1'b1;
                    if (!seen_q) begin
                        first_d = w_val;
                        seen_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_RESET;
        endcase

        if (count_err && (cnt_q != {ERR_W{1'b1}}))
            cnt_d = cnt_q + ERR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RESET;
            one_q        <= 4'd0;
            ten_q        <= 4'd0;
            value_q      <= 7'd0;
            prev_q       <= 7'd0;
            prev_ud_q    <= 1'b0;
            prev_pause_q <= 1'b0;
            err_q        <= 1'b0;
            bad_q        <= 1'b0;
            cnt_q        <= '0;
            first_q      <= 7'd0;
            seen_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            one_q        <= w_one;
            ten_q        <= w_ten;
            value_q      <= w_val;
            // Always follows the observed value, which also resynchronises after a mismatch
            prev_q       <= w_val;
            prev_ud_q    <= ud;
            prev_pause_q <= pause;
            err_q        <= err_d;
            bad_q        <= bad_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
            seen_q       <= seen_d;
        end
    end

    assign ONE           = one_q;
    assign TEN           = ten_q;
    assign value         = value_q;
    assign locked        = (state_q == ST_TRACK);
    assign err           = err_q;
    assign bad_seg       = bad_q;
    assign err_cnt       = cnt_q;
    assign first_err_val = first_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_count_checker.sv
// ============================================================================
//  Module      : tb_seg_count_checker
//  Description : Scoreboard bench for seg_count_checker (ERR_W=8 and ERR_W=2)
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_seg_count_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ud = 1'b1;
    logic       pause = 1'b1;
    logic [6:0] onesseg = 7'b0000001;
    logic [6:0] tensseg = 7'b0000001;

    logic [3:0] one, ten;
    logic [6:0] value;
    logic       locked, err, bad_seg;
    logic [7:0] err_cnt;
    logic [6:0] first_err_val;

    logic [3:0] one2, ten2;
    logic [6:0] value2;
    logic       locked2, err2, bad_seg2;
    logic [1:0] err_cnt2;
    logic [6:0] first_err_val2;

    int n_cmp = 0;
    int n_bad = 0;
    int row   = 0;

    typedef struct {
        int   row;
        int   ev;
        int   eone;
        int   eten;
        logic el;
        logic ee;
        logic eb;
        int   ec;
        int   ef;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    seg_count_checker #(.ERR_W(8)) dut (
        .clk(clk), .rst(rst), .ud(ud), .pause(pause),
        .onesseg(onesseg), .tensseg(tensseg),
        .ONE(one), .TEN(ten), .value(value), .locked(locked),
        .err(err), .bad_seg(bad_seg), .err_cnt(err_cnt),
        .first_err_val(first_err_val)
    );

    seg_count_checker #(.ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .ud(ud), .pause(pause),
        .onesseg(onesseg), .tensseg(tensseg),
        .ONE(one2), .TEN(ten2), .value(value2), .locked(locked2),
        .err(err2), .bad_seg(bad_seg2), .err_cnt(err_cnt2),
        .first_err_val(first_err_val2)
    );

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'b0000001;
            1: seg = 7'b1001111;
            2: seg = 7'b0010010;
            3: seg = 7'b0000110;
            4: seg = 7'b1001100;
            5: seg = 7'b0100100;
            6: seg = 7'b0100000;
            7: seg = 7'b0001111;
            8: seg = 7'b0000000;
            9: seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic vec(input logic r, input logic [6:0] os, input logic [6:0] ts,
                       input logic u, input logic p, input int ev, input int eone_ovr,
                       input logic el, input logic ee, input logic eb,
                       input int ec, input int ef);
        exp_t e;
        @(negedge clk);
        rst     = r;
        onesseg = os;
        tensseg = ts;
        ud      = u;
        pause   = p;
        row++;
        e.row = row;
        e.ev  = ev;
        if (ev >= 0) begin
            e.eone = ev % 10;
            e.eten = ev / 10;
        end else begin
            e.eone = eone_ovr;
            e.eten = -1;
        end
        e.el = el;
        e.ee = ee;
        e.eb = eb;
        e.ec = ec;
        e.ef = ef;
        sb.push_back(e);
    endtask

    task automatic vn(input logic r, input int n, input logic u, input logic p,
                      input int ev, input logic el, input logic ee, input logic eb,
                      input int ec, input int ef);
        vec(r, seg(n % 10), seg(n / 10), u, p, ev, -1, el, ee, eb, ec, ef);
    endtask

    // Monitor: the DUT presents a new output set every cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.ev >= 0)
                    chk($sformatf("r%0d value", e.row), int'(value), e.ev);
                if (e.eone >= 0)
                    chk($sformatf("r%0d ONE", e.row), int'(one), e.eone);
                if (e.eten >= 0)
                    chk($sformatf("r%0d TEN", e.row), int'(ten), e.eten);
                chk($sformatf("r%0d locked", e.row), int'(locked), int'(e.el));
                chk($sformatf("r%0d err", e.row), int'(err), int'(e.ee));
                chk($sformatf("r%0d bad_seg", e.row), int'(bad_seg), int'(e.eb));
                chk($sformatf("r%0d err_cnt", e.row), int'(err_cnt), e.ec);
                chk($sformatf("r%0d first_err_val", e.row), int'(first_err_val), e.ef);
                chk($sformatf("r%0d err(W2)", e.row), int'(err2), int'(e.ee));
                chk($sformatf("r%0d err_cnt(W2)", e.row), int'(err_cnt2), (e.ec > 3) ? 3 : e.ec);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // rst, n, ud, pause | value, locked, err, bad, err_cnt, first_err_val
        vn(1,  0, 1, 1,   0, 0, 0, 0, 0,  0);
        vn(1,  0, 1, 1,   0, 0, 0, 0, 0,  0);
        vn(0,  0, 1, 1,   0, 0, 0, 0, 0,  0);
        vn(0,  0, 1, 1,   0, 1, 0, 0, 0,  0);
        vn(0,  0, 1, 0,   0, 1, 0, 0, 0,  0);
        vn(0,  1, 0, 0,   1, 1, 0, 0, 0,  0);
        vn(0,  0, 0, 0,   0, 1, 0, 0, 0,  0);
        vn(0, 99, 0, 0,  99, 1, 0, 0, 0,  0);
        vn(0, 98, 0, 0,  98, 1, 0, 0, 0,  0);
        vn(0, 97, 1, 0,  97, 1, 0, 0, 0,  0);
        vn(0, 98, 1, 0,  98, 1, 0, 0, 0,  0);
        vn(0, 99, 1, 0,  99, 1, 0, 0, 0,  0);
        vn(0,  0, 1, 0,   0, 1, 0, 0, 0,  0);
        vn(0,  1, 0, 0,   1, 1, 0, 0, 0,  0);
        vn(0,  0, 0, 0,   0, 1, 0, 0, 0,  0);
        vn(0, 99, 0, 0,  99, 1, 0, 0, 0,  0);
        // relock at 42, hold, then a forced jump to 44
        vn(1, 42, 1, 1,   0, 0, 0, 0, 0,  0);
        vn(0, 42, 1, 1,  42, 0, 0, 0, 0,  0);
        vn(0, 42, 1, 1,  42, 1, 0, 0, 0,  0);
        vn(0, 42, 1, 1,  42, 1, 0, 0, 0,  0);
        vn(0, 42, 1, 1,  42, 1, 0, 0, 0,  0);
        vn(0, 42, 1, 1,  42, 1, 0, 0, 0,  0);
        vn(0, 42, 1, 1,  42, 1, 0, 0, 0,  0);
        vn(0, 42, 1, 0,  42, 1, 0, 0, 0,  0);
        vn(0, 44, 1, 0,  44, 1, 1, 0, 1, 44);
        vn(0, 45, 1, 0,  45, 1, 0, 0, 1, 44);
        // blank ones digit for one cycle
        vec(0, 7'b1111111, seg(4), 1, 0, -1, 15, 0, 0, 1, 2, 44);
        vn(0, 47, 1, 0,  47, 1, 0, 0, 2, 44);
        vn(0, 48, 1, 0,  48, 1, 0, 0, 2, 44);
        vn(0, 50, 1, 0,  50, 1, 1, 0, 3, 44);
        // reset with err_cnt at 3 and a mismatching display on the same edge
        vn(1, 60, 1, 0,   0, 0, 0, 0, 0,  0);
        vn(0, 10, 1, 0,  10, 0, 0, 0, 0,  0);
        vn(0, 10, 1, 0,  10, 1, 0, 0, 0,  0);
        vn(0, 20, 1, 0,  20, 1, 1, 0, 1, 20);
        vn(0, 30, 1, 0,  30, 1, 1, 0, 2, 20);
        vn(0, 33, 1, 0,  33, 1, 1, 0, 3, 20);
        vn(0, 50, 1, 0,  50, 1, 1, 0, 4, 20);
        vn(0, 63, 1, 0,  63, 1, 1, 0, 5, 20);
        vn(0, 64, 1, 0,  64, 1, 0, 0, 5, 20);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        chk("scoreboard drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg_count_checker.md
# seg_count_checker

Self-checking monitor for the two-digit 00–99 up/down counter. It sits beside the counter in the top-level bench and in on-board debug builds, watching the counter's `onesseg`/`tensseg` seven-segment outputs together with its `ud`/`pause` controls. It decodes the segment patterns back to BCD digits, tracks the expected count, and flags any display value that is illegal or out of sequence. It is the decoding end of the counter's BCD-to-seven-segment encoding.

## Interface
Parameters:
- `ERR_W`, 8: width of the saturating error counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ud`  in  1  counter direction as driven to the counter; 1 = up, 0 = down.
- `pause`  in  1  counter hold as driven to the counter; 1 = hold.
- `onesseg`  in  7  ones-digit segments `{a,b,c,d,e,f,g}`, active-low.
- `tensseg`  in  7  tens-digit segments, same encoding.
- `ONE`  out  4  decoded ones BCD digit.
- `TEN`  out  4  decoded tens BCD digit.
- `value`  out  7  binary value, computed as `TEN*10+ONE` (0–99).
- `locked`  out  1  checker is in the TRACK state.
- `err`  out  1  one-cycle pulse on each detected mismatch.
- `bad_seg`  out  1  one-cycle pulse when a digit pattern is not a legal 0–9 code.
- `err_cnt`  out  ERR_W  total errors (mismatch plus bad_seg), saturating at all-ones.
- `first_err_val`  out  7  `value` observed at the first mismatch since reset.

## Operation
- Legal codes, active-low `{a..g}`:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
- Any other pattern decodes to digit 4'hF and is illegal.
- Decode is combinational. `ONE`, `TEN` and `value` are registered copies of the current decode.
- The previous value `prev`, `prev_ud` and `prev_pause` are registered every cycle.
- Expected value:
  - if `prev_pause`: `prev`
  - else if `prev_ud`: 99 → 0, otherwise `prev+1`
  - else: 0 → 99, otherwise `prev-1`
- FSM states:
  - RESET_S: entered on `rst`. Goes to SYNC on the next cycle.
  - SYNC: waits for both digits legal. Captures `prev` and moves to TRACK. No compare is done in SYNC.
  - TRACK: each cycle, compares the decoded value against the expected value.
    - Mismatch: pulse `err`, increment `err_cnt`, and latch `first_err_val` if this is the first mismatch. Stay in TRACK and resynchronise by setting `prev` to the observed value.
    - Illegal digit: pulse `bad_seg`, increment `err_cnt`, return to SYNC. No `err` pulse that cycle.
- Simultaneous illegal digit and mismatch count once, as `bad_seg`.
- `err_cnt` saturates at all-ones; further errors still pulse `err`/`bad_seg`.
- Reset values:
  - state RESET_S, `locked` 0, `err` 0, `bad_seg` 0
  - `err_cnt` 0, `first_err_val` 0
  - `ONE` 0, `TEN` 0, `value` 0, `prev` 0
- Reset asserted mid-operation clears everything on that edge. It overrides any pending error.

## Timing
- The counter updates on a rising edge. The checker samples its segments and controls on the same edge, one cycle later than the counter sampled them.
- Segment change to `ONE`/`TEN`/`value` update: 1 cycle.
- Mismatch at sample k: `err` is high in cycle k+1, and `err_cnt` reflects it in the same cycle.
- After `rst` deasserts:
  - RESET_S occupies 1 cycle, then SYNC.
  - With legal segments, `locked` rises 2 cycles after `rst` deasserts.
  - The first compare happens on the following sample.
- `ud`/`pause` changes are honoured from the cycle in which they are sampled. They take effect on the next compare.

## Structure
- Shared package `seg7_pkg`:
  - segment code constants `SEG_0`..`SEG_9` (shared with the counter's encoder)
  - illegal-digit constant `DIG_BAD = 4'hF`
  - state enumeration constants `ST_RESET`, `ST_SYNC`, `ST_TRACK`
  - `MAX_COUNT = 99`
- Sub-module `seg7_decode`: purely combinational 7→4 decoder with a legal flag. Instantiated twice, once for ones and once for tens.

## Test plan
- Reset with a legal "00" display → `locked` = 0, then 1 two cycles after `rst` drops. `err_cnt` = 0.
- `ud` = 1, counter stepping 97, 98, 99, 00 → `value` follows 97, 98, 99, 0 with no `err`. Repeat downward through 01, 00, 99 with no `err`.
- `pause` = 1 with the display held at 42 for 5 cycles → no `err`. A forced jump 42 → 44 with `pause` = 0 → one `err` pulse, `err_cnt` = 1, `first_err_val` = 44.
- Force `onesseg` = 1111111 for 1 cycle → `bad_seg` pulse, `ONE` = 4'hF, `locked` drops. It relocks on the next legal sample with no `err`.
- Assert `rst` while `err_cnt` = 3 → all outputs return to reset values on that edge.
- `ERR_W` = 2, inject 5 mismatches → `err_cnt` stops at 3 and `err` pulses 5 times.
